// File: rtl/linked_list_drain_pkg.sv
// Shared types for the per-flow out-of-order packet linked list.
// Holds the list BRAM entry layout and the address widths used by the list reader.
package linked_list_drain_pkg;

    localparam int LL_AWIDTH  = 8;
    localparam int PKT_AWIDTH = 12;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           seq;
        logic [15:0]           len;
        logic [LL_AWIDTH-1:0]  next;
        logic [PKT_AWIDTH-1:0] pktID;
        logic [4:0]            flits;
        logic                  last;
        logic [55:0]           last_7_bytes;
    } entry_t;

endpackage

// File: rtl/linked_list_drain.sv
// Reader side of a per-flow packet linked list: emits in-order nodes from the head and frees them.
// Optional LL_DRAIN_STALE_DROP_EN: silently invalidate/free nodes that lie entirely before the expected seq.
module linked_list_drain
    import linked_list_drain_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    input  logic [LL_AWIDTH-1:0]  head_ptr,
    input  logic [31:0]           exp_seq,
    output logic                  done,
    output logic [LL_AWIDTH-1:0]  new_head,
    output logic [31:0]           new_seq,
    output logic                  list_empty,
    output logic [7:0]            drained,
    output logic                  ll_rd,
    output logic [LL_AWIDTH-1:0]  ll_rd_addr,
    input  entry_t                ll_rd_data,
    output logic                  ll_wr,
    output logic [LL_AWIDTH-1:0]  ll_wr_addr,
    output entry_t                ll_wr_data,
    output logic                  free_valid,
    input  logic                  free_ready,
    output logic [LL_AWIDTH-1:0]  free_addr,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [PKT_AWIDTH-1:0] pkt_id,
    output logic [4:0]            pkt_flits,
    output logic [31:0]           pkt_seq,
    output logic [15:0]           pkt_len,
    output logic [55:0]           pkt_last_7_bytes
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_EVAL, S_EMIT, S_FREE, S_FIN
    } state_t;

    state_t                state, state_nxt;
    logic [LL_AWIDTH-1:0]  addr;
    logic [31:0]           seq_r;
    logic [7:0]            count;
    logic                  list_empty_r;
    logic                  drop_r;
    entry_t                entry_r;
    logic [RD_LAT-1:0]     rd_vld_p;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef LL_DRAIN_STALE_DROP_EN
    // A node is stale when its whole byte range ends at or before the expected seq.
    function automatic logic is_stale(input entry_t e, input logic [31:0] s);
        logic signed [31:0] d;
        d = e.seq + 32'(e.len) - s;
        return (d <= 32'sd0);
    endfunction
`endif

    always_comb begin
        state_nxt  = state;
        ll_rd      = 1'b0;
        ll_wr      = 1'b0;
        free_valid = 1'b0;
        pkt_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:    if (start) state_nxt = S_RD_REQ;
            S_RD_REQ: begin
                ll_rd     = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: if (rd_vld_p[RD_LAT-1]) state_nxt = S_EVAL;
            S_EVAL: begin
                if (!entry_r.valid)
                    state_nxt = S_FIN;
                else if (entry_r.seq == seq_r)
                    state_nxt = S_EMIT;
`ifdef LL_DRAIN_STALE_DROP_EN
                else if (is_stale(entry_r, seq_r)) begin
                    ll_wr     = 1'b1;
                    state_nxt = S_FREE;
                end
`endif
                else
                    state_nxt = S_FIN;
            end
            S_EMIT: begin
                pkt_valid = 1'b1;
                if (pkt_ready) begin
                    ll_wr     = 1'b1;
                    state_nxt = S_FREE;
                end
            end
            S_FREE: begin
                free_valid = 1'b1;
                if (free_ready) state_nxt = entry_r.last ? S_FIN : S_RD_REQ;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_vld_p     <= '0;
            addr         <= '0;
            seq_r        <= '0;
            count        <= '0;
            list_empty_r <= 1'b0;
            drop_r       <= 1'b0;
            entry_r      <= '0;
        end else begin
            state    <= state_nxt;
            // read-valid pipe: bit RD_LAT-1 marks the cycle the BRAM q holds our entry
            rd_vld_p <= (rd_vld_p << 1) | RD_LAT'(ll_rd);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr         <= head_ptr;
                        seq_r        <= exp_seq;
                        count        <= '0;
                        list_empty_r <= 1'b0;
                        drop_r       <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (rd_vld_p[RD_LAT-1]) entry_r <= ll_rd_data;
                end
                S_EVAL: begin
                    list_empty_r <= !entry_r.valid;
                    drop_r       <= (state_nxt == S_FREE);
                end
                S_FREE: begin
                    if (free_ready) begin
                        if (!drop_r) begin
                            seq_r <= seq_r + 32'(entry_r.len);
                            count <= sat_inc8(count);
                        end
                        if (entry_r.last) list_empty_r <= 1'b1;
                        else              addr         <= entry_r.next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state != S_IDLE);
    assign new_head         = addr;
    assign new_seq          = seq_r;
    assign list_empty       = list_empty_r;
    assign drained          = count;
    assign ll_rd_addr       = addr;
    assign ll_wr_addr       = addr;
    assign ll_wr_data       = '0;
    assign free_addr        = addr;
    assign pkt_id           = entry_r.pktID;
    assign pkt_flits        = entry_r.flits;
    assign pkt_seq          = entry_r.seq;
    assign pkt_len          = entry_r.len;
    assign pkt_last_7_bytes = entry_r.last_7_bytes;

endmodule

// File: tb/tb_linked_list_drain.sv
// Scoreboard bench for linked_list_drain: directed lists in a BRAM model, monitor pops expected events.
module tb_linked_list_drain;
    import linked_list_drain_pkg::*;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << LL_AWIDTH;

    logic                  clk = 1'b0;
    logic                  rst, start, busy, done, list_empty;
    logic [LL_AWIDTH-1:0]  head_ptr, new_head, ll_rd_addr, ll_wr_addr, free_addr;
    logic [31:0]           exp_seq, new_seq, pkt_seq;
    logic [7:0]            drained;
    logic                  ll_rd, ll_wr, free_valid, free_ready, pkt_valid, pkt_ready;
    entry_t                ll_rd_data, ll_wr_data;
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [4:0]            pkt_flits;
    logic [15:0]           pkt_len;
    logic [55:0]           pkt_last_7_bytes;

    linked_list_drain #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .head_ptr(head_ptr),
        .exp_seq(exp_seq), .done(done), .new_head(new_head), .new_seq(new_seq),
        .list_empty(list_empty), .drained(drained), .ll_rd(ll_rd), .ll_rd_addr(ll_rd_addr),
        .ll_rd_data(ll_rd_data), .ll_wr(ll_wr), .ll_wr_addr(ll_wr_addr), .ll_wr_data(ll_wr_data),
        .free_valid(free_valid), .free_ready(free_ready), .free_addr(free_addr),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_id(pkt_id), .pkt_flits(pkt_flits),
        .pkt_seq(pkt_seq), .pkt_len(pkt_len), .pkt_last_7_bytes(pkt_last_7_bytes)
    );

    always #5 clk = ~clk;

    // BRAM model with RD_LAT-cycle read latency and a bench-side load/clear port
    entry_t               mem [DEPTH];
    entry_t               q_pipe [RD_LAT];
    logic                 ld_en = 1'b0, clr = 1'b0;
    logic [LL_AWIDTH-1:0] ld_addr = '0;
    entry_t               ld_data = '0;

    always @(posedge clk) begin
        if (clr) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (ld_en) mem[ld_addr] <= ld_data;
        else if (ll_wr) mem[ll_wr_addr] <= ll_wr_data;
        if (ll_rd) q_pipe[0] <= mem[ll_rd_addr];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ll_rd_data = q_pipe[RD_LAT-1];

    typedef struct packed {
        logic [PKT_AWIDTH-1:0] id;
        logic [31:0]           seq;
        logic [15:0]           len;
    } pkt_exp_t;
    typedef struct packed {
        logic [LL_AWIDTH-1:0] head;
        logic [31:0]          seq;
        logic                 le;
        logic [7:0]           dr;
    } done_exp_t;

    pkt_exp_t             pkt_q[$];
    done_exp_t            done_q[$];
    logic [LL_AWIDTH-1:0] wr_q[$];
    logic [LL_AWIDTH-1:0] free_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: got an event, required none", name);
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge
    pkt_exp_t  pe, hold;
    done_exp_t de;
    logic      hold_v = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && pkt_valid)
                check("pkt_hold", 160'({pkt_id, pkt_seq, pkt_len}), 160'(hold));
            hold_v = pkt_valid && !pkt_ready;
            hold   = '{id: pkt_id, seq: pkt_seq, len: pkt_len};
            if (pkt_valid && pkt_ready) begin
                if (pkt_q.size() == 0) unexpected("pkt");
                else begin
                    pe = pkt_q.pop_front();
                    check("pkt", 160'({pkt_id, pkt_seq, pkt_len}), 160'(pe));
                end
            end
            if (ll_wr) begin
                check("rd_wr_excl", 160'(ll_rd), '0);
                check("wr_data", 160'(ll_wr_data), '0);
                if (wr_q.size() == 0) unexpected("ll_wr");
                else check("wr_addr", 160'(ll_wr_addr), 160'(wr_q.pop_front()));
            end
            if (free_valid && free_ready) begin
                if (free_q.size() == 0) unexpected("free");
                else check("free_addr", 160'(free_addr), 160'(free_q.pop_front()));
            end
            if (done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    de = done_q.pop_front();
                    check("done_result", 160'({new_head, new_seq, list_empty, drained}), 160'(de));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic entry_t mk(input logic [31:0] s, input logic [15:0] l,
                                  input logic [LL_AWIDTH-1:0] n, input logic lst,
                                  input logic [PKT_AWIDTH-1:0] id);
        entry_t e;
        e = '0;
        e.valid = 1'b1; e.seq = s; e.len = l; e.next = n; e.last = lst;
        e.pktID = id; e.flits = 5'd4; e.last_7_bytes = 56'(s);
        return e;
    endfunction

    task automatic put(input logic [LL_AWIDTH-1:0] a, input entry_t d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic clear_mem();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic exp_node(input logic [LL_AWIDTH-1:0] a, input logic [PKT_AWIDTH-1:0] id,
                            input logic [31:0] s, input logic [15:0] l);
        pkt_q.push_back('{id: id, seq: s, len: l});
        wr_q.push_back(a);
        free_q.push_back(a);
    endtask

    task automatic exp_done(input logic [LL_AWIDTH-1:0] h, input logic [31:0] s,
                            input logic le, input logic [7:0] dr);
        done_q.push_back('{head: h, seq: s, le: le, dr: dr});
    endtask

    task automatic issue(input logic [LL_AWIDTH-1:0] h, input logic [31:0] s);
        head_ptr = h; exp_seq = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        if (!got) unexpected({name, "_timeout"});
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, 160'({busy, done, new_head, new_seq, list_empty, drained, ll_rd,
                                    ll_rd_addr, ll_wr, ll_wr_addr, free_valid, free_addr, pkt_valid}), '0);
        check({name, "_pkt"}, 160'({pkt_id, pkt_flits, pkt_seq, pkt_len, pkt_last_7_bytes}), '0);
        check({name, "_wrdata"}, 160'(ll_wr_data), '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; head_ptr = '0; exp_seq = '0;
        pkt_ready = 1'b1; free_ready = 1'b1;
        clear_mem();
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // single last node
        put(8'd5, mk(32'd100, 16'd50, 8'd0, 1'b1, 12'h105));
        exp_node(8'd5, 12'h105, 32'd100, 16'd50);
        exp_done(8'd5, 32'd150, 1'b1, 8'd1);
        issue(8'd5, 32'd100);
        wait_done("t1");

        // two in-order nodes, stop at a gap
        clear_mem();
        put(8'd5, mk(32'd100, 16'd50, 8'd9, 1'b0, 12'h205));
        put(8'd9, mk(32'd150, 16'd20, 8'd3, 1'b0, 12'h209));
        put(8'd3, mk(32'd300, 16'd10, 8'd0, 1'b1, 12'h203));
        exp_node(8'd5, 12'h205, 32'd100, 16'd50);
        exp_node(8'd9, 12'h209, 32'd150, 16'd20);
        exp_done(8'd3, 32'd170, 1'b0, 8'd2);
        issue(8'd5, 32'd100);
        wait_done("t2");

        // gap at the head
        clear_mem();
        put(8'd8, mk(32'd200, 16'd10, 8'd0, 1'b1, 12'h308));
        exp_done(8'd8, 32'd100, 1'b0, 8'd0);
        issue(8'd8, 32'd100);
        wait_done("t3");

        // seq wrap-around
        clear_mem();
        put(8'd7, mk(32'hFFFF_FFF0, 16'd32, 8'd0, 1'b1, 12'h407));
        exp_node(8'd7, 12'h407, 32'hFFFF_FFF0, 16'd32);
        exp_done(8'd7, 32'h0000_0010, 1'b1, 8'd1);
        issue(8'd7, 32'hFFFF_FFF0);
        wait_done("t4");

        // invalid head node: nothing to drain, list reported empty
        exp_done(8'd30, 32'd77, 1'b1, 8'd0);
        issue(8'd30, 32'd77);
        wait_done("t_invalid");

        // backpressure on both pkt and free handshakes
        clear_mem();
        put(8'd12, mk(32'd500, 16'd40, 8'd0, 1'b1, 12'h50C));
        exp_node(8'd12, 12'h50C, 32'd500, 16'd40);
        exp_done(8'd12, 32'd540, 1'b1, 8'd1);
        pkt_ready = 1'b0; free_ready = 1'b0;
        issue(8'd12, 32'd500);
        for (int i = 0; i < 50 && !pkt_valid; i++) tick();
        repeat (10) tick();
        pkt_ready = 1'b1;
        for (int i = 0; i < 50 && !free_valid; i++) tick();
        repeat (5) tick();
        free_ready = 1'b1;
        wait_done("t5");

        // reset while waiting for BRAM data, then a clean walk
        clear_mem();
        put(8'd20, mk(32'd600, 16'd8, 8'd0, 1'b1, 12'h614));
        issue(8'd20, 32'd600);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        repeat (6) tick();
        exp_node(8'd20, 12'h614, 32'd600, 16'd8);
        exp_done(8'd20, 32'd608, 1'b1, 8'd1);
        issue(8'd20, 32'd600);
        wait_done("t6");

        // node entirely before the expected seq
        clear_mem();
        put(8'd40, mk(32'd50, 16'd20, 8'd41, 1'b0, 12'h728));
        put(8'd41, mk(32'd100, 16'd10, 8'd0, 1'b1, 12'h729));
`ifdef LL_DRAIN_STALE_DROP_EN
        wr_q.push_back(8'd40);
        free_q.push_back(8'd40);
        exp_node(8'd41, 12'h729, 32'd100, 16'd10);
        exp_done(8'd41, 32'd110, 1'b1, 8'd1);
`else
        exp_done(8'd40, 32'd100, 1'b0, 8'd0);
`endif
        issue(8'd40, 32'd100);
        wait_done("t_stale");

        repeat (3) tick();
        check("queues_empty", 160'(pkt_q.size() + wr_q.size() + free_q.size() + done_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
